cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Round-robin scheduler that shares the single common data bus (CDB) among the functional-unit result ports, one per RS entry.
- Each requester owns a one-entry holding buffer, so a finished FU can drop its result and free its RS entry's pipeline slot without waiting.
- Each cycle at most one buffered result is granted and broadcast as a registered CDB packet (ROB tag + value).
- It also emits the per-entry done pulse consumed by the RS free logic.
- It sits between the FU outputs and the RS/ROB/map-table CDB inputs.

## Interface
Parameters:
- NUM_REQ, 6: number of requesters; bit k maps to RS entry k+1.
- TAG_W, 5: ROB tag width. Tag 0 means "no tag".
- DATA_W, 32: result value width.

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- squash  input  1  synchronous flush of all buffered and pending results.
- req_valid  input  NUM_REQ  FU k presents a result.
- req_tag  input  NUM_REQ*TAG_W  ROB tag of FU k, slice [k*TAG_W +: TAG_W].
- req_data  input  NUM_REQ*DATA_W  result value of FU k.
- req_ready  output  NUM_REQ  buffer k can accept this cycle.
- cdb_valid  output  1  CDB packet valid.
- cdb_tag  output  TAG_W  broadcast ROB tag.
- cdb_data  output  DATA_W  broadcast value.
- fu_done  output  NUM_REQ  one-hot pulse; entry k's result is on the CDB this cycle.

## Operation
- Per-requester state: full[k], tag[k], data[k].
- req_ready[k] = !full[k] || grant[k]. A same-cycle refill of a granted buffer is allowed.
- Accept rule: req_valid[k] && req_ready[k] at the edge loads the buffer and sets full[k].
- Arbitration is combinational over full[] only. There is no bypass from req_* straight to the CDB.
- Priority scan starts at index ptr, goes ptr, ptr+1, …, NUM_REQ-1, then 0, …, ptr-1. The first full buffer wins.
- grant is one-hot or zero. The granted buffer clears at the edge unless it is refilled at the same edge.
- Pointer update: after a grant to k, ptr <= (k+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0. With no grant, ptr holds.
- CDB register: at the edge, cdb_valid <= |grant, cdb_tag/cdb_data <= the granted buffer, fu_done <= grant.
- With no grant, cdb_valid, cdb_tag, cdb_data and fu_done all go to 0. A tag of 0 is never left stale on the bus.
- Squash, at the edge where squash=1:
  - all full[] are cleared;
  - any accept that cycle is discarded;
  - cdb_valid and fu_done go to 0 on the next cycle;
  - ptr holds;
  - req_ready is unaffected combinationally.
- Squash has priority over accept, grant and refill.
- Reset (reset_n=0, asynchronous): full=0, ptr=0, cdb_valid=0, cdb_tag=0, cdb_data=0, fu_done=0, req_ready=all ones.
- Reset mid-operation discards all buffered results.

## Timing
- Latency: result accepted at edge c is granted no earlier than cycle c+1. cdb_valid/fu_done are visible in cycle c+2 at the earliest.
- Throughput: one broadcast per cycle overall.
- A single requester alone sustains one result per cycle via same-cycle refill.
- Worst-case wait for a full buffer is NUM_REQ-1 grants. Starvation-free.
- fu_done[k] is a one-cycle pulse, coincident with cdb_valid.
- All outputs except req_ready are registered. req_ready is combinational from full[] and grant.

## Configuration
- CDB_ARB_FIXED_PRIO_EN defined: ptr is forced to 0 and never updates. The lowest index always wins (entry 1 has the highest priority); no starvation guarantee.
- CDB_ARB_FIXED_PRIO_EN undefined (default): round-robin as specified above.

## Test plan
- Reset then single request:
  - stimulus: reset_n low then high; req_valid=000001, tag=3, data=0xDEAD_BEEF for one cycle;
  - response: req_ready=111111 during reset; cdb_valid=1, tag=3, data=0xDEADBEEF, fu_done=000001 exactly two cycles after the request; all zero afterwards.
- Round-robin wrap:
  - stimulus: all six requesters load tags 1..6 in the same cycle, none refilled;
  - response: broadcast order tags 1,2,3,4,5,6 on six consecutive cycles; the next lone request at k=0 with tag 9 is granted with ptr wrapped to 0.
- Fairness under contention:
  - stimulus: k=0 and k=5 hold req_valid continuously with fresh tags;
  - response: grants alternate 0,5,0,5; both req_ready stay 1 on their granted cycles; no gaps in cdb_valid.
- Squash:
  - stimulus: buffers k=1,2 full, squash=1 for one cycle while req_valid[3]=1;
  - response: no CDB broadcast for tags in k=1,2,3; cdb_valid=0 the cycle after squash; ptr unchanged.
- Asynchronous reset mid-broadcast:
  - stimulus: drop reset_n between edges while cdb_valid=1;
  - response: cdb_valid, fu_done and full[] clear immediately without a clock edge.
- With CDB_ARB_FIXED_PRIO_EN:
  - stimulus: k=0 and k=2 request continuously;
  - response: k=0 granted every cycle; k=2 never granted while k=0 stays full.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin CDB scheduler with a one-entry holding buffer per FU; broadcast 2 cycles after accept, ready = !full || grant.
// Build option CDB_ARB_FIXED_PRIO_EN pins the scan start to entry 0 (fixed priority, lowest index wins).
module cdb_arbiter #(
  parameter int NUM_REQ = 6,
  parameter int TAG_W   = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      squash,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [NUM_REQ-1:0]        fu_done
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] full_q, full_d;
  logic [TAG_W-1:0]   tag_q  [NUM_REQ];
  logic [TAG_W-1:0]   tag_d  [NUM_REQ];
  logic [DATA_W-1:0]  data_q [NUM_REQ];
  logic [DATA_W-1:0]  data_d [NUM_REQ];
  logic [PTR_W-1:0]   ptr_q, ptr_d;

  logic               cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0]  cdb_data_q, cdb_data_d;
  logic [NUM_REQ-1:0] fu_done_q, fu_done_d;

  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] accept;
  logic [PTR_W-1:0]   gidx;
  logic               found;
  logic [PTR_W:0]     scan;

  // Rotating scan from ptr_q; only buffered results compete, never the live inputs.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    scan  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (scan >= (PTR_W+1)'(NUM_REQ)) begin
        scan = scan - (PTR_W+1)'(NUM_REQ);
      end
      if (!found && full_q[scan[PTR_W-1:0]]) begin
        found                    = 1'b1;
        grant[scan[PTR_W-1:0]]   = 1'b1;
        gidx                     = scan[PTR_W-1:0];
      end
    end
  end

  assign req_ready = ~full_q | grant;
  assign accept    = req_valid & req_ready;

  always_comb begin
    full_d      = full_q;
    tag_d       = tag_q;
    data_d      = data_q;
    ptr_d       = ptr_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = '0;
    cdb_data_d  = '0;
    fu_done_d   = '0;
    if (squash) begin
      full_d = '0;
    end else begin
      // A granted buffer that is refilled at the same edge stays full.
      full_d = (full_q & ~grant) | accept;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (accept[k]) begin
          tag_d[k]  = req_tag[k*TAG_W +: TAG_W];
          data_d[k] = req_data[k*DATA_W +: DATA_W];
        end
      end
      if (found) begin
        cdb_valid_d = 1'b1;
        cdb_tag_d   = tag_q[gidx];
        cdb_data_d  = data_q[gidx];
        fu_done_d   = grant;
`ifdef CDB_ARB_FIXED_PRIO_EN
        ptr_d       = '0;
`else
        ptr_d       = (gidx == PTR_W'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      full_q      <= '0;
      ptr_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      fu_done_q   <= '0;
      for (int k = 0; k < NUM_REQ; k++) begin
        tag_q[k]  <= '0;
        data_q[k] <= '0;
      end
    end else begin
      full_q      <= full_d;
      ptr_q       <= ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      fu_done_q   <= fu_done_d;
      for (int k = 0; k < NUM_REQ; k++) begin
        tag_q[k]  <= tag_d[k];
        data_q[k] <= data_d[k];
      end
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign fu_done   = fu_done_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter; inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_cdb_arbiter;
  localparam int N  = 6;
  localparam int TW = 5;
  localparam int DW = 32;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              squash = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N*TW-1:0]   req_tag = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N-1:0]      req_ready;
  logic              cdb_valid;
  logic [TW-1:0]     cdb_tag;
  logic [DW-1:0]     cdb_data;
  logic [N-1:0]      fu_done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  cdb_arbiter #(.NUM_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .squash    (squash),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .fu_done   (fu_done)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset;
    squash    = 1'b0;
    req_valid = '0;
    reset_n   = 1'b0;
    #2;
    reset_n   = 1'b1;
    tick();
  endtask

  task automatic set_req(input int k, input logic [TW-1:0] t, input logic [DW-1:0] d);
    req_valid[k]         = 1'b1;
    req_tag[k*TW +: TW]  = t;
    req_data[k*DW +: DW] = d;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #2;
    total_cnt++; if (req_ready !== 6'b111111) $display("FAIL reset_ready got %b want 111111", req_ready); else pass_cnt++;
    total_cnt++; if (cdb_valid !== 1'b0) $display("FAIL reset_vld got %b want 0", cdb_valid); else pass_cnt++;
    total_cnt++; if (fu_done !== 6'b0) $display("FAIL reset_done got %b want 000000", fu_done); else pass_cnt++;
    total_cnt++; if (cdb_tag !== 5'd0 || cdb_data !== 32'd0) $display("FAIL reset_bus got tag %0d data %h want 0 0", cdb_tag, cdb_data); else pass_cnt++;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single;
    set_req(0, 5'd3, 32'hDEAD_BEEF);
    tick();
    req_valid = '0;
    total_cnt++; if (cdb_valid !== 1'b0) $display("FAIL single_early got %b want 0", cdb_valid); else pass_cnt++;
    total_cnt++; if (req_ready !== 6'b111111) $display("FAIL single_ready got %b want 111111", req_ready); else pass_cnt++;
    tick();
    total_cnt++; if (cdb_valid !== 1'b1) $display("FAIL single_vld got %b want 1", cdb_valid); else pass_cnt++;
    total_cnt++; if (cdb_tag !== 5'd3) $display("FAIL single_tag got %0d want 3", cdb_tag); else pass_cnt++;
    total_cnt++; if (cdb_data !== 32'hDEAD_BEEF) $display("FAIL single_data got %h want deadbeef", cdb_data); else pass_cnt++;
    total_cnt++; if (fu_done !== 6'b000001) $display("FAIL single_done got %b want 000001", fu_done); else pass_cnt++;
    tick();
    total_cnt++; if (cdb_valid !== 1'b0 || cdb_tag !== 5'd0 || cdb_data !== 32'd0 || fu_done !== 6'b0)
      $display("FAIL single_idle got vld %b tag %0d data %h done %b want all 0", cdb_valid, cdb_tag, cdb_data, fu_done); else pass_cnt++;
  endtask

  task automatic test_rr_wrap;
    logic [TW-1:0] et;
    logic [N-1:0]  ed;
    apply_reset();
    for (int k = 0; k < N; k++) set_req(k, TW'(k + 1), 32'h100 + k);
    tick();
    req_valid = '0;
    total_cnt++; if (req_ready !== 6'b000001) $display("FAIL rr_ready got %b want 000001", req_ready); else pass_cnt++;
    for (int k = 0; k < N; k++) begin
      tick();
      et = TW'(k + 1);
      ed = N'(1) << k;
      total_cnt++; if (cdb_valid !== 1'b1 || cdb_tag !== et || fu_done !== ed || cdb_data !== 32'h100 + k)
        $display("FAIL rr_slot%0d got vld %b tag %0d done %b data %h want 1 %0d %b %h", k, cdb_valid, cdb_tag, fu_done, cdb_data, et, ed, 32'h100 + k);
      else pass_cnt++;
    end
    set_req(0, 5'd9, 32'h99);
    tick();
    req_valid = '0;
    total_cnt++; if (cdb_valid !== 1'b0) $display("FAIL rr_gap got %b want 0", cdb_valid); else pass_cnt++;
    tick();
    total_cnt++; if (cdb_tag !== 5'd9 || fu_done !== 6'b000001 || cdb_valid !== 1'b1)
      $display("FAIL rr_wrap got tag %0d done %b vld %b want 9 000001 1", cdb_tag, fu_done, cdb_valid); else pass_cnt++;
  endtask

  task automatic test_fairness;
    logic [TW-1:0] t0, t5, et;
    logic [N-1:0]  r, ed;
    apply_reset();
    t0 = 5'd10;
    t5 = 5'd20;
    set_req(0, t0, 32'hA0);
    set_req(5, t5, 32'hB0);
    for (int c = 0; c < 9; c++) begin
      r = req_ready;
      tick();
      if (r[0]) t0 = t0 + 1'b1;
      if (r[5]) t5 = t5 + 1'b1;
      set_req(0, t0, 32'hA0);
      set_req(5, t5, 32'hB0);
      if (c >= 1) begin
        if (c % 2 == 1) begin
          et = TW'(10 + (c - 1) / 2);
          ed = 6'b000001;
        end else begin
          et = TW'(20 + (c - 2) / 2);
          ed = 6'b100000;
        end
        total_cnt++; if (cdb_valid !== 1'b1 || cdb_tag !== et || fu_done !== ed)
          $display("FAIL fair_c%0d got vld %b tag %0d done %b want 1 %0d %b", c, cdb_valid, cdb_tag, fu_done, et, ed);
        else pass_cnt++;
        total_cnt++; if ((r & ed) !== ed) $display("FAIL fair_ready_c%0d got %b want granted bit of %b set", c, r, ed); else pass_cnt++;
      end
    end
    req_valid = '0;
    repeat (3) tick();
  endtask

  task automatic test_fixed_prio;
    logic [TW-1:0] t0;
    logic [N-1:0]  r;
    apply_reset();
    t0 = 5'd10;
    set_req(0, t0, 32'hA0);
    set_req(2, 5'd30, 32'hC0);
    for (int c = 0; c < 6; c++) begin
      r = req_ready;
      tick();
      if (r[0]) t0 = t0 + 1'b1;
      set_req(0, t0, 32'hA0);
      if (c >= 1) begin
        total_cnt++; if (fu_done !== 6'b000001 || cdb_tag !== TW'(10 + c - 1))
          $display("FAIL fixed_c%0d got done %b tag %0d want 000001 %0d", c, fu_done, cdb_tag, 10 + c - 1); else pass_cnt++;
        total_cnt++; if (r[2] !== 1'b0) $display("FAIL fixed_ready2_c%0d got %b want 0", c, r[2]); else pass_cnt++;
      end
    end
    req_valid = '0;
    repeat (3) tick();
  endtask

  task automatic test_squash;
    apply_reset();
    set_req(1, 5'd7, 32'h7);
    set_req(2, 5'd8, 32'h8);
    tick();
    req_valid = '0;
    squash    = 1'b1;
    set_req(3, 5'd11, 32'hB);
    #1;
    total_cnt++; if (req_ready !== 6'b111011) $display("FAIL squash_ready got %b want 111011", req_ready); else pass_cnt++;
    tick();
    squash    = 1'b0;
    req_valid = '0;
    total_cnt++; if (cdb_valid !== 1'b0 || fu_done !== 6'b0) $display("FAIL squash_next got vld %b done %b want 0 000000", cdb_valid, fu_done); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++; if (cdb_valid !== 1'b0) $display("FAIL squash_quiet%0d got vld %b tag %0d want 0", i, cdb_valid, cdb_tag); else pass_cnt++;
    end
    set_req(0, 5'd12, 32'hC);
    set_req(5, 5'd13, 32'hD);
    tick();
    req_valid = '0;
    tick();
    total_cnt++; if (cdb_tag !== 5'd12 || fu_done !== 6'b000001) $display("FAIL squash_ptr_first got tag %0d done %b want 12 000001", cdb_tag, fu_done); else pass_cnt++;
    tick();
    total_cnt++; if (cdb_tag !== 5'd13 || fu_done !== 6'b100000) $display("FAIL squash_ptr_second got tag %0d done %b want 13 100000", cdb_tag, fu_done); else pass_cnt++;
  endtask

  task automatic test_async_reset;
    apply_reset();
    set_req(0, 5'd4, 32'h4);
    set_req(1, 5'd5, 32'h5);
    set_req(2, 5'd6, 32'h6);
    tick();
    req_valid = '0;
    tick();
    total_cnt++; if (cdb_valid !== 1'b1 || cdb_tag !== 5'd4) $display("FAIL arst_pre got vld %b tag %0d want 1 4", cdb_valid, cdb_tag); else pass_cnt++;
    total_cnt++; if (req_ready !== 6'b111011) $display("FAIL arst_pre_ready got %b want 111011", req_ready); else pass_cnt++;
    #2;
    reset_n = 1'b0;
    #1;
    total_cnt++; if (cdb_valid !== 1'b0 || fu_done !== 6'b0 || cdb_tag !== 5'd0)
      $display("FAIL arst_out got vld %b done %b tag %0d want 0 000000 0", cdb_valid, fu_done, cdb_tag); else pass_cnt++;
    total_cnt++; if (req_ready !== 6'b111111) $display("FAIL arst_full got ready %b want 111111", req_ready); else pass_cnt++;
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total_cnt++; if (cdb_valid !== 1'b0) $display("FAIL arst_after%0d got vld %b tag %0d want 0", i, cdb_valid, cdb_tag); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_wrap();
`ifdef CDB_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_fairness();
`endif
    test_squash();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule
